// File: rtl/cache_page_transfer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : cache_page_transfer_sequencer
// Description : Moves one cache page between the cache SRAM primary port and
//               the QSPI RAM device. An optional writeback phase streams the
//               old page out (SRAM read -> QSPI store), then the load phase
//               streams the new page in (QSPI read -> SRAM write).
// Ports       : wb_clk_i/wb_rst_i       clock, synchronous active-high reset
//               enable                  subsystem enable, low aborts
//               req_*                   request handshake and page fields
//               done/aborted/busy       transfer status
//               qspi_*                  QSPI device command/handshake
//               sram_*                  SRAM primary port access
// Revision    : 1.0 - initial release
// ============================================================================
module cache_page_transfer_sequencer #(
    parameter int ADDRESS_SIZE            = 24,
    parameter int SRAM_ADDRESS_SIZE       = 9,
    parameter int PAGE_INDEX_ADDRESS_SIZE = 4
) (
    input  logic                                   wb_clk_i,
    input  logic                                   wb_rst_i,
    input  logic                                   enable,
    input  logic                                   req_valid,
    output logic                                   req_ready,
    input  logic [PAGE_INDEX_ADDRESS_SIZE-1:0]     req_page,
    input  logic                                   req_writeback,
    input  logic [ADDRESS_SIZE-3-(SRAM_ADDRESS_SIZE-PAGE_INDEX_ADDRESS_SIZE):0] req_wb_page_number,
    input  logic [ADDRESS_SIZE-3-(SRAM_ADDRESS_SIZE-PAGE_INDEX_ADDRESS_SIZE):0] req_ld_page_number,
    output logic                                   done,
    output logic                                   aborted,
    output logic                                   busy,
    output logic [ADDRESS_SIZE-1:0]                qspi_address,
    output logic                                   qspi_changeAddress,
    output logic                                   qspi_requestData,
    output logic                                   qspi_storeData,
    output logic                                   qspi_interruptOperation,
    input  logic                                   qspi_wordComplete,
    input  logic                                   qspi_initialised,
    input  logic                                   qspi_busy,
    output logic                                   sram_enable,
    output logic                                   sram_write_enable,
    output logic [SRAM_ADDRESS_SIZE-1:0]           sram_address,
    input  logic                                   sram_busy
);

    localparam int c_WORD_BITS        = SRAM_ADDRESS_SIZE - PAGE_INDEX_ADDRESS_SIZE;
    localparam int c_PAGE_NUMBER_SIZE = ADDRESS_SIZE - 2 - c_WORD_BITS;

    localparam logic [c_WORD_BITS-1:0] c_WORD_ONE = 1;

    localparam logic [3:0] c_IDLE     = 4'd0;
    localparam logic [3:0] c_WB_ADDR  = 4'd1;
    localparam logic [3:0] c_WB_READ  = 4'd2;
    localparam logic [3:0] c_WB_STORE = 4'd3;
    localparam logic [3:0] c_LD_ADDR  = 4'd4;
    localparam logic [3:0] c_LD_WAIT  = 4'd5;
    localparam logic [3:0] c_LD_WRITE = 4'd6;
    localparam logic [3:0] c_DONE     = 4'd7;
    localparam logic [3:0] c_ABORT    = 4'd8;

    logic [3:0]                         r_state;
    logic [c_WORD_BITS-1:0]             r_word_index;
    logic [PAGE_INDEX_ADDRESS_SIZE-1:0] r_page;
    logic [c_PAGE_NUMBER_SIZE-1:0]      r_ld_page;
    logic [ADDRESS_SIZE-1:0]            r_qspi_address;

    logic w_accept;
    logic w_last_word;
    logic w_active;

    assign w_accept    = (r_state == c_IDLE) && req_valid && enable && qspi_initialised;
    assign w_last_word = &r_word_index;
    // States in which a falling enable must abandon the transfer.
    assign w_active    = (r_state != c_IDLE) && (r_state != c_ABORT);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state        <= c_IDLE;
            r_word_index   <= '0;
            r_page         <= '0;
            r_ld_page      <= '0;
            r_qspi_address <= '0;
        end else if (w_active && !enable) begin
            r_state <= c_ABORT;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (w_accept) begin
                        r_page    <= req_page;
                        r_ld_page <= req_ld_page_number;
                        // The phase address is staged here so it is already
                        // stable when changeAddress pulses.
                        if (req_writeback) begin
                            r_qspi_address <= {req_wb_page_number, {c_WORD_BITS{1'b0}}, 2'b00};
                            r_state        <= c_WB_ADDR;
                        end else begin
                            r_qspi_address <= {req_ld_page_number, {c_WORD_BITS{1'b0}}, 2'b00};
                            r_state        <= c_LD_ADDR;
                        end
                    end
                end
                c_WB_ADDR: begin
                    if (!qspi_busy) r_state <= c_WB_READ;
                end
                c_WB_READ: begin
                    if (!sram_busy) r_state <= c_WB_STORE;
                end
                c_WB_STORE: begin
                    if (qspi_wordComplete) begin
                        if (w_last_word) begin
                            r_word_index   <= '0;
                            r_qspi_address <= {r_ld_page, {c_WORD_BITS{1'b0}}, 2'b00};
                            r_state        <= c_LD_ADDR;
                        end else begin
                            r_word_index <= r_word_index + c_WORD_ONE;
                            r_state      <= c_WB_READ;
                        end
                    end
                end
                c_LD_ADDR: begin
                    if (!qspi_busy) r_state <= c_LD_WAIT;
                end
                c_LD_WAIT: begin
                    if (qspi_wordComplete) r_state <= c_LD_WRITE;
                end
                c_LD_WRITE: begin
                    if (!sram_busy) begin
                        if (w_last_word) begin
                            r_state <= c_DONE;
                        end else begin
                            r_word_index <= r_word_index + c_WORD_ONE;
                            r_state      <= c_LD_WAIT;
                        end
                    end
                end
                c_DONE, c_ABORT: begin
                    r_word_index <= '0;
                    r_state      <= c_IDLE;
                end
                default: begin
                    r_word_index <= '0;
                    r_state      <= c_IDLE;
                end
            endcase
        end
    end

    // Every strobe is gated by enable so an abort drops them in the same
    // cycle enable falls, before the state register reaches ABORT.
    assign req_ready               = (r_state == c_IDLE);
    assign busy                    = (r_state != c_IDLE);
    assign done                    = (r_state == c_DONE) && enable;
    assign aborted                 = (r_state == c_ABORT);
    assign qspi_interruptOperation = (r_state == c_ABORT);
    assign qspi_address            = r_qspi_address;
    assign qspi_changeAddress      = ((r_state == c_WB_ADDR) || (r_state == c_LD_ADDR))
                                     && !qspi_busy && enable;
    assign qspi_requestData        = (r_state == c_LD_WAIT) && enable;
    assign qspi_storeData          = (r_state == c_WB_STORE) && enable;
    assign sram_enable             = ((r_state == c_WB_READ) || (r_state == c_LD_WRITE)) && enable;
    assign sram_write_enable       = (r_state == c_LD_WRITE) && enable;
    assign sram_address            = {r_page, r_word_index};

endmodule
`default_nettype wire

// File: tb/tb_cache_page_transfer_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_page_transfer_sequencer
// Description : Randomized bench for cache_page_transfer_sequencer. Random
//               QSPI/SRAM responders; the observed event stream is compared
//               with a stream derived from page/word arithmetic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_page_transfer_sequencer;

    logic        wb_clk_i = 1'b0;
    logic        wb_rst_i;
    logic        enable;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_page;
    logic        req_writeback;
    logic [16:0] req_wb_page_number;
    logic [16:0] req_ld_page_number;
    logic        done;
    logic        aborted;
    logic        busy;
    logic [23:0] qspi_address;
    logic        qspi_changeAddress;
    logic        qspi_requestData;
    logic        qspi_storeData;
    logic        qspi_interruptOperation;
    logic        qspi_wordComplete;
    logic        qspi_initialised;
    logic        qspi_busy;
    logic        sram_enable;
    logic        sram_write_enable;
    logic [8:0]  sram_address;
    logic        sram_busy;

    cache_page_transfer_sequencer dut (
        .wb_clk_i                (wb_clk_i),
        .wb_rst_i                (wb_rst_i),
        .enable                  (enable),
        .req_valid               (req_valid),
        .req_ready               (req_ready),
        .req_page                (req_page),
        .req_writeback           (req_writeback),
        .req_wb_page_number      (req_wb_page_number),
        .req_ld_page_number      (req_ld_page_number),
        .done                    (done),
        .aborted                 (aborted),
        .busy                    (busy),
        .qspi_address            (qspi_address),
        .qspi_changeAddress      (qspi_changeAddress),
        .qspi_requestData        (qspi_requestData),
        .qspi_storeData          (qspi_storeData),
        .qspi_interruptOperation (qspi_interruptOperation),
        .qspi_wordComplete       (qspi_wordComplete),
        .qspi_initialised        (qspi_initialised),
        .qspi_busy               (qspi_busy),
        .sram_enable             (sram_enable),
        .sram_write_enable       (sram_write_enable),
        .sram_address            (sram_address),
        .sram_busy               (sram_busy)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    int          n_checks = 0;
    int          n_errors = 0;

    // Event stream: [31:28] kind, low bits payload.
    // 1 changeAddress(addr) 2 SRAM read(addr) 3 store done 4 load word done
    // 5 SRAM write(addr) 6 done 7 aborted
    logic [31:0] got_q[$];
    int          sw_count;
    int          st_count;
    bit          end_seen;
    int          stage;
    bit          hold_mode;
    int          hold_cnt;
    bit          prev_hold;
    logic [10:0] prev_sram;
    logic        s_busy;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic sample();
        check_eq("excl", 32'({qspi_requestData && qspi_storeData, sram_enable && qspi_changeAddress}), 32'd0);
        if (prev_hold)
            check_eq("sram_hold", 32'({sram_enable, sram_write_enable, sram_address}), 32'(prev_sram));
        prev_hold = sram_enable && sram_busy;
        prev_sram = {sram_enable, sram_write_enable, sram_address};
        s_busy    = busy;
        if (qspi_changeAddress) got_q.push_back({4'h1, 4'h0, qspi_address});
        if (sram_enable && !sram_busy) begin
            got_q.push_back({sram_write_enable ? 4'h5 : 4'h2, 19'h0, sram_address});
            if (sram_write_enable) sw_count++;
        end
        if (qspi_storeData && qspi_wordComplete) begin
            got_q.push_back(32'h3000_0000);
            st_count++;
        end
        if (qspi_requestData && qspi_wordComplete) got_q.push_back(32'h4000_0000);
        if (done) begin
            got_q.push_back(32'h6000_0000);
            end_seen = 1'b1;
        end
        if (aborted) begin
            got_q.push_back(32'h7000_0000);
            end_seen = 1'b1;
        end
        case (stage)
            1: begin
                check_eq("abort_strobes", 32'({qspi_requestData, qspi_storeData, sram_enable,
                                               qspi_changeAddress, done}), 32'd0);
                stage = 2;
            end
            2: begin
                check_eq("abort_pulse", 32'({qspi_interruptOperation, aborted, done}), 32'b110);
                stage = 3;
            end
            3: begin
                check_eq("abort_idle", 32'({req_ready, busy, qspi_interruptOperation, aborted}), 32'b1000);
                stage = 0;
            end
            default: ;
        endcase
    endtask

    task automatic respond();
        qspi_busy         = ($urandom_range(0, 3) == 0);
        qspi_wordComplete = ($urandom_range(0, 2) == 0);
        if (hold_mode) begin
            if (sram_enable && hold_cnt < 3) begin
                sram_busy = 1'b1;
                hold_cnt++;
            end else begin
                sram_busy = 1'b0;
                hold_cnt  = 0;
            end
        end else begin
            sram_busy = ($urandom_range(0, 2) == 0);
        end
    endtask

    task automatic cycle();
        @(negedge wb_clk_i);
        sample();
        @(posedge wb_clk_i);
        #1;
        respond();
    endtask

    task automatic check_reset_values();
        check_eq("rst_ctrl", 32'({req_ready, busy, done, aborted, qspi_changeAddress, qspi_requestData,
                                  qspi_storeData, qspi_interruptOperation, sram_enable, sram_write_enable}),
                 32'b10_0000_0000);
        check_eq("rst_qaddr", 32'(qspi_address), 32'd0);
        check_eq("rst_saddr", 32'(sram_address), 32'd0);
    endtask

    // mode 0: normal, 1: abort at load word 7, 2: reset after 10 stores,
    // 3: qspi_initialised low for a while before the request is taken.
    task automatic do_transfer(input logic [3:0] page, input logic wb, input logic [16:0] wbpn,
                               input logic [16:0] ldpn, input int mode);
        logic [31:0] exp_q[$];
        int          ld_words;
        int          n_cmp;
        got_q.delete();
        sw_count = 0;
        st_count = 0;
        end_seen = 1'b0;
        stage    = 0;
        ld_words = (mode == 1) ? 7 : 32;

        // Reference stream: page number * 128 bytes per page, page*32 + i words.
        if (wb) begin
            exp_q.push_back(32'h1000_0000 | (32'(wbpn) * 128));
            for (int i = 0; i < 32; i++) begin
                exp_q.push_back(32'h2000_0000 | (32'(page) * 32 + 32'(i)));
                exp_q.push_back(32'h3000_0000);
            end
        end
        exp_q.push_back(32'h1000_0000 | (32'(ldpn) * 128));
        for (int i = 0; i < ld_words; i++) begin
            exp_q.push_back(32'h4000_0000);
            exp_q.push_back(32'h5000_0000 | (32'(page) * 32 + 32'(i)));
        end
        exp_q.push_back((mode == 1) ? 32'h7000_0000 : 32'h6000_0000);

        req_page           = page;
        req_writeback      = wb;
        req_wb_page_number = wbpn;
        req_ld_page_number = ldpn;
        req_valid          = 1'b1;

        if (mode == 3) begin
            qspi_initialised = 1'b0;
            for (int k = 0; k < 3; k++) begin
                @(negedge wb_clk_i);
                check_eq("noinit", 32'({req_ready, busy, qspi_changeAddress, qspi_requestData,
                                        qspi_storeData, sram_enable}), 32'b100000);
                @(posedge wb_clk_i);
                #1;
            end
            qspi_initialised = 1'b1;
        end

        @(negedge wb_clk_i);
        check_eq("pre_accept", 32'({req_ready, busy}), 32'b10);
        @(posedge wb_clk_i);
        #1;
        req_valid = 1'b0;
        cycle();
        check_eq("accepted", 32'(s_busy), 32'd1);

        for (int n = 0; n < 5000 && !end_seen; n++) begin
            cycle();
            if (mode == 1 && sw_count == 7 && stage == 0 && enable) begin
                enable            = 1'b0;
                qspi_wordComplete = 1'b0;
                stage             = 1;
            end
            if (mode == 2 && st_count == 10) begin
                wb_rst_i = 1'b1;
                cycle();
                wb_rst_i  = 1'b0;
                prev_hold = 1'b0;
                @(negedge wb_clk_i);
                check_reset_values();
                @(posedge wb_clk_i);
                #1;
                return;
            end
        end
        check_eq("end_seen", 32'(end_seen), 32'd1);
        enable = 1'b1;
        cycle();

        check_eq("log_len", 32'(got_q.size()), 32'(exp_q.size()));
        n_cmp = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n_cmp; i++)
            check_eq($sformatf("log%0d", i), got_q[i], exp_q[i]);
    endtask

    initial begin
        wb_rst_i           = 1'b1;
        enable             = 1'b1;
        req_valid          = 1'b0;
        req_page           = '0;
        req_writeback      = 1'b0;
        req_wb_page_number = '0;
        req_ld_page_number = '0;
        qspi_wordComplete  = 1'b0;
        qspi_initialised   = 1'b1;
        qspi_busy          = 1'b0;
        sram_busy          = 1'b0;
        hold_mode          = 1'b0;
        hold_cnt           = 0;
        prev_hold          = 1'b0;
        prev_sram          = '0;
        s_busy             = 1'b0;
        repeat (3) @(posedge wb_clk_i);
        #1;
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        check_reset_values();
        @(posedge wb_clk_i);
        #1;

        // Load only, then writeback + load at the highest page slot.
        do_transfer(4'd3, 1'b0, 17'h00000, 17'h00010, 0);
        do_transfer(4'd15, 1'b1, 17'h00001, 17'h00002, 0);

        // SRAM stalls for three cycles on every access.
        hold_mode = 1'b1;
        do_transfer(4'($urandom_range(0, 15)), 1'b1, 17'($urandom), 17'($urandom), 0);
        hold_mode = 1'b0;

        // Abort in the middle of the load phase.
        do_transfer(4'($urandom_range(0, 15)), 1'b0, 17'($urandom), 17'($urandom), 1);

        // Request held while the device is not yet initialised.
        do_transfer(4'($urandom_range(0, 15)), 1'b0, 17'($urandom), 17'($urandom), 3);

        // Reset during writeback, then a clean transfer from word 0.
        do_transfer(4'($urandom_range(0, 15)), 1'b1, 17'($urandom), 17'($urandom), 2);
        do_transfer(4'($urandom_range(0, 15)), 1'b1, 17'($urandom), 17'($urandom), 0);

        for (int t = 0; t < 4; t++)
            do_transfer(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                        17'($urandom), 17'($urandom), 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
